// File: rtl/over_tracker.sv
// Over-level view of the innings: legal balls, completed overs, per-over runs,
// delivery history, maiden detection and the free-hit flag after a no-ball.
module over_tracker #(
    parameter int BALLS_PER_OVER = 6,
    parameter int MAX_OVERS      = 20,
    parameter int HIST_DEPTH     = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ball_sw_i,
    input  logic [3:0]              lfsr_out_i,
    input  logic                    team_sw_i,
    input  logic                    inning_over_i,
    input  logic                    game_over_i,
    output logic [2:0]              balls_in_over_o,
    output logic [4:0]              overs_o,
    output logic [5:0]              over_runs_o,
    output logic [5:0]              last_over_runs_o,
    output logic                    maiden_o,
    output logic                    over_done_o,
    output logic                    free_hit_o,
    output logic                    overs_max_o,
    output logic [4*HIST_DEPTH-1:0] hist_o,
    output logic [3:0]              hist_cnt_o
);

    localparam logic [2:0] BPO_L  = 3'(BALLS_PER_OVER);
    localparam logic [4:0] MAXO_L = 5'(MAX_OVERS);
    localparam logic [3:0] HD_L   = 4'(HIST_DEPTH);
    localparam int         HW     = 4 * HIST_DEPTH;

    logic          ball_sw_q, team_sw_q;
    logic [2:0]    balls_q, balls_d;
    logic [4:0]    overs_q, overs_d;
    logic [5:0]    over_runs_q, over_runs_d;
    logic [5:0]    last_q, last_d;
    logic          maiden_q, maiden_d;
    logic          over_done_q, over_done_d;
    logic          free_hit_q, free_hit_d;
    logic [HW-1:0] hist_q, hist_d;
    logic [3:0]    hist_cnt_q, hist_cnt_d;
    logic          pend_q, pend_d;

    logic          code_valid, code_legal;
    logic [2:0]    code_runs;
    logic [6:0]    runs_sum;
    logic [5:0]    runs_sat;
    logic [2:0]    balls_inc;
    logic          team_toggle, delivery;

    always_comb begin
        code_valid = 1'b1;
        code_legal = 1'b1;
        code_runs  = 3'd0;
        case (lfsr_out_i)
            4'd1: code_runs = 3'd0;
            4'd2: code_runs = 3'd1;
            4'd3: code_runs = 3'd2;
            4'd4: code_runs = 3'd4;
            4'd5: code_runs = 3'd6;
            4'd6: code_runs = 3'd0;
            4'd7, 4'd8: begin
                code_runs  = 3'd1;
                code_legal = 1'b0;
            end
            default: begin
                code_valid = 1'b0;
                code_legal = 1'b0;
            end
        endcase
    end

    assign runs_sum    = {1'b0, over_runs_q} + {4'd0, code_runs};
    assign runs_sat    = runs_sum[6] ? 6'd63 : runs_sum[5:0];
    assign balls_inc   = balls_q + 3'd1;
    assign team_toggle = team_sw_i ^ team_sw_q;
    assign delivery    = ball_sw_i & ~ball_sw_q & ~inning_over_i & ~game_over_i
                       & (overs_q != MAXO_L);

    always_comb begin
        balls_d     = balls_q;
        overs_d     = overs_q;
        over_runs_d = over_runs_q;
        last_d      = last_q;
        maiden_d    = maiden_q;
        over_done_d = 1'b0;
        free_hit_d  = free_hit_q;
        hist_d      = hist_q;
        hist_cnt_d  = hist_cnt_q;
        pend_d      = pend_q;

        if (team_toggle) begin
            balls_d     = '0;
            overs_d     = '0;
            over_runs_d = '0;
            last_d      = '0;
            maiden_d    = 1'b0;
            free_hit_d  = 1'b0;
            hist_d      = '0;
            hist_cnt_d  = '0;
            pend_d      = 1'b0;
        end else if (delivery && code_valid) begin
            // A completed over is kept on display until the next valid ball replaces it.
            if (pend_q) begin
                hist_d     = {{(HW-4){1'b0}}, lfsr_out_i};
                hist_cnt_d = 4'd1;
                pend_d     = 1'b0;
            end else begin
                hist_d = {hist_q[HW-5:0], lfsr_out_i};
                if (hist_cnt_q != HD_L) hist_cnt_d = hist_cnt_q + 4'd1;
            end

            if (lfsr_out_i == 4'd8) free_hit_d = 1'b1;
            else if (code_legal)    free_hit_d = 1'b0;

            if (code_legal && (balls_inc == BPO_L)) begin
                balls_d     = '0;
                overs_d     = overs_q + 5'd1;
                last_d      = runs_sat;
                maiden_d    = (runs_sat == 6'd0);
                over_done_d = 1'b1;
                over_runs_d = '0;
                pend_d      = 1'b1;
            end else begin
                if (code_legal) balls_d = balls_inc;
                over_runs_d = runs_sat;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ball_sw_q   <= 1'b0;
            team_sw_q   <= team_sw_i;
            balls_q     <= '0;
            overs_q     <= '0;
            over_runs_q <= '0;
            last_q      <= '0;
            maiden_q    <= 1'b0;
            over_done_q <= 1'b0;
            free_hit_q  <= 1'b0;
            hist_q      <= '0;
            hist_cnt_q  <= '0;
            pend_q      <= 1'b0;
        end else begin
            ball_sw_q   <= ball_sw_i;
            team_sw_q   <= team_sw_i;
            balls_q     <= balls_d;
            overs_q     <= overs_d;
            over_runs_q <= over_runs_d;
            last_q      <= last_d;
            maiden_q    <= maiden_d;
            over_done_q <= over_done_d;
            free_hit_q  <= free_hit_d;
            hist_q      <= hist_d;
            hist_cnt_q  <= hist_cnt_d;
            pend_q      <= pend_d;
        end
    end

    assign balls_in_over_o  = balls_q;
    assign overs_o          = overs_q;
    assign over_runs_o      = over_runs_q;
    assign last_over_runs_o = last_q;
    assign maiden_o         = maiden_q;
    assign over_done_o      = over_done_q;
    assign free_hit_o       = free_hit_q;
    assign overs_max_o      = (overs_q == MAXO_L);
    assign hist_o           = hist_q;
    assign hist_cnt_o       = hist_cnt_q;

endmodule

// File: doc/over_tracker.md
Name: over_tracker

Overview:
- Sits beside score_and_wickets and ball_counter, downstream of the debounced ball switch and the LFSR.
- Decodes each delivery outcome (lfsr_out) into an over-level view: legal balls in the current over, completed overs, runs conceded this over, a short delivery history, maiden detection and the free-hit flag after a no-ball.
- Feeds the seven-segment controller's over display and the celebration logic.

Parameters:
- BALLS_PER_OVER, 6, legal deliveries per over.
- MAX_OVERS, 20, overs per innings; deliveries are ignored once this count is reached.
- HIST_DEPTH, 8, deliveries held in the current-over history buffer.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-low reset
- ball_sw  input  1  debounced ball switch, level; a rising edge marks one delivery
- lfsr_out  input  4  delivery code, sampled on the delivery edge
- team_sw  input  1  batting team select; any toggle starts a new innings
- inning_over  input  1  freeze: deliveries ignored while high
- game_over  input  1  freeze: deliveries ignored while high
- balls_in_over  output  3  legal balls bowled in the current over, 0..5
- overs  output  5  completed overs, 0..MAX_OVERS
- over_runs  output  6  runs conceded in the current over, saturating at 63
- last_over_runs  output  6  runs conceded in the previous completed over
- maiden  output  1  previous completed over conceded 0 runs
- over_done  output  1  one-cycle pulse when an over completes
- free_hit  output  1  next delivery is a free hit
- overs_max  output  1  overs == MAX_OVERS
- hist  output  4*HIST_DEPTH  delivery codes of the current over; entry 0 in bits [3:0] is the newest
- hist_cnt  output  4  valid history entries, 0..HIST_DEPTH

Behaviour:
- Reset (rst=0 at a clk edge; overrides everything): all outputs are 0, including hist; the internal ball_sw_q register is 0.
- Delivery event: ball_sw=1 and ball_sw_q=0 at a clk edge, with inning_over=0, game_over=0 and overs_max=0. State updates on that edge, so results are visible one cycle after the edge is sampled.
  - A held switch produces exactly one event.
  - ball_sw_q tracks ball_sw every cycle, including during freeze.
- Delivery code decode:
  - 1: dot, 0 runs, legal
  - 2: 1 run, legal
  - 3: 2 runs, legal
  - 4: 4 runs, legal
  - 5: 6 runs, legal
  - 6: wicket, 0 runs, legal
  - 7: wide, 1 run, not legal
  - 8: no-ball, 1 run, not legal
  - Codes 0 and 9-15 are invalid: no state change.
- Run accounting: over_runs increases by the decoded runs and saturates at 63.
- Free hit:
  - free_hit sets after code 8.
  - It clears after the next legal delivery.
  - It persists across wides (code 7) and across another no-ball.
- History:
  - Each valid delivery is shifted into entry 0; older entries move up.
  - When hist_cnt == HIST_DEPTH, the oldest entry is dropped and hist_cnt stays at HIST_DEPTH.
- Over completion (the legal delivery that makes BALLS_PER_OVER):
  - balls_in_over wraps to 0 and overs increments.
  - last_over_runs takes the final over_runs including this ball; maiden = (that value == 0).
  - over_done pulses for exactly one cycle, the cycle after the edge.
  - over_runs resets to 0.
  - hist and hist_cnt are held for display. A pending-clear flag sets; the next valid delivery first clears hist and then writes itself as entry 0 with hist_cnt=1.
- Cap: when overs reaches MAX_OVERS, overs_max=1 and all further events are ignored.
- New innings: a team_sw toggle (team_sw differs from its registered copy) clears every output and the pending-clear flag on that edge. If a delivery edge coincides with the toggle, the clear wins and the delivery is dropped.
- Freeze: while inning_over or game_over is high, all outputs hold. over_done may still complete a pulse already in progress, i.e. it is registered and drops the next cycle.
- Widths: overs uses 5 bits (MAX_OVERS ≤ 31); balls_in_over uses 3 bits (BALLS_PER_OVER ≤ 7).

Test Plan:
- Reset, then codes 2,3,1,4,6,5 as six edges:
  - over_done pulses once after the 6th edge.
  - overs=1, balls_in_over=0, last_over_runs=13, maiden=0.
  - hist_cnt=6, hist[3:0]=5.
- Six code-1 deliveries: maiden=1, last_over_runs=0. Then one code-7: hist_cnt=1 (cleared then written), over_runs=1, balls_in_over=0.
- Codes 8,7,2: free_hit=1 after the 8, stays 1 after the 7, is 0 after the 2; over_runs=3, balls_in_over=1.
- Ten consecutive code-7 deliveries: hist_cnt=8, over_runs=10, balls_in_over=0; hist holds the newest eight entries.
- Hold ball_sw high for 50 cycles: exactly one delivery counted. Assert inning_over and pulse ball_sw: outputs unchanged.
- MAX_OVERS=2, bowl 12 legal balls then a 13th: overs=2, overs_max=1, and the 13th changes nothing. Toggle team_sw on the same edge as a delivery: all outputs 0. Drive rst=0 mid-over: all outputs 0 next cycle.
